// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among N byte producers.
// A byte without "last" locks the grant so multi-byte messages stay contiguous.
module uart_tx_arbiter #(
    parameter int N       = 4,
    parameter int LOCK_TO = 1023
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   last,
    input  logic [8*N-1:0] data,
    output logic [N-1:0]   ack,
    output logic [N-1:0]   grant,
    output logic           lock_drop,
    output logic           tx_start,
    output logic [7:0]     tx_data,
    input  logic           tx_ready
);

    localparam int PW = $clog2(N);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;

    state_t        state, state_d;
    logic [PW-1:0] rr, rr_d, owner, owner_d;
    logic          lock, lock_d, last_r, last_r_d;
    logic [9:0]    to_cnt, to_cnt_d;
    logic [N-1:0]  ack_d, grant_d;
    logic          lock_drop_d, tx_start_d;
    logic [7:0]    tx_data_d;

    logic          pick_vld;
    logic [PW-1:0] pick;
    logic          issue;
    logic [PW-1:0] issue_idx;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(N-1)) ? '0 : p + 1'b1;
    endfunction

    // Scan from the highest offset down so the requester nearest rr wins.
    always_comb begin
        int idx;
        idx      = 0;
        pick_vld = 1'b0;
        pick     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(rr) + k) % N;
            if (req[idx]) begin
                pick_vld = 1'b1;
                pick     = PW'(idx);
            end
        end
    end

    always_comb begin
        state_d     = state;
        rr_d        = rr;
        owner_d     = owner;
        lock_d      = lock;
        last_r_d    = last_r;
        to_cnt_d    = to_cnt;
        ack_d       = '0;
        grant_d     = grant;
        lock_drop_d = 1'b0;
        tx_start_d  = tx_start;
        tx_data_d   = tx_data;
        issue       = 1'b0;
        issue_idx   = owner;

        case (state)
            IDLE: begin
                if (lock) begin
                    if (req[owner]) begin
                        issue = 1'b1;
                    end else begin
                        if (to_cnt != 10'(LOCK_TO))
                            to_cnt_d = to_cnt + 10'd1;
                        if (to_cnt_d == 10'(LOCK_TO)) begin
                            lock_d      = 1'b0;
                            grant_d     = '0;
                            lock_drop_d = 1'b1;
                            rr_d        = wrap_inc(owner);
                        end
                    end
                end else if (pick_vld) begin
                    issue     = 1'b1;
                    issue_idx = pick;
                end
                if (issue) begin
                    owner_d    = issue_idx;
                    grant_d    = N'(1) << issue_idx;
                    tx_data_d  = data[int'(issue_idx)*8 +: 8];
                    last_r_d   = last[issue_idx];
                    tx_start_d = 1'b1;
                    to_cnt_d   = '0;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                // Ready falling is the transmitter's acceptance of the byte.
                if (!tx_ready) begin
                    tx_start_d   = 1'b0;
                    ack_d[owner] = 1'b1;
                    state_d      = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (tx_ready) begin
                    state_d = IDLE;
                    if (last_r) begin
                        lock_d  = 1'b0;
                        grant_d = '0;
                        rr_d    = wrap_inc(owner);
                    end else begin
                        lock_d   = 1'b1;
                        to_cnt_d = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            rr        <= '0;
            owner     <= '0;
            lock      <= 1'b0;
            last_r    <= 1'b0;
            to_cnt    <= '0;
            ack       <= '0;
            grant     <= '0;
            lock_drop <= 1'b0;
            tx_start  <= 1'b0;
            tx_data   <= '0;
        end else begin
            state     <= state_d;
            rr        <= rr_d;
            owner     <= owner_d;
            lock      <= lock_d;
            last_r    <= last_r_d;
            to_cnt    <= to_cnt_d;
            ack       <= ack_d;
            grant     <= grant_d;
            lock_drop <= lock_drop_d;
            tx_start  <= tx_start_d;
            tx_data   <= tx_data_d;
        end
    end

endmodule
